// File: rtl/imem_loader.sv
// Boot loader: assembles a length-prefixed, XOR-checksummed byte stream into
// little-endian 32-bit words, writes them from address 0, then releases the cpu.
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int NUM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        S_HDR0  = 3'd0,
        S_HDR1  = 3'd1,
        S_DATA  = 3'd2,
        S_CSUM  = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam logic [16:0] MAX_COUNT = 17'(NUM_WORDS);

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready.
    state_t      state, next_state;
    logic        hs;
    logic [7:0]  count_lo;
    logic [15:0] count;
    logic [15:0] hdr_count;
    logic [1:0]  byte_idx;
    logic [7:0]  xsum;
    logic [23:0] word_buf;
    logic        last_byte;
    logic        last_word;
    logic        in_ready_d, done_d, error_d, cpu_rst_d;

    assign hs        = in_valid & in_ready;
    assign hdr_count = {in_data, count_lo};
    assign last_byte = (byte_idx == 2'd3);
    // words_loaded still holds the index of the word being assembled here.
    assign last_word = ((words_loaded + 16'd1) == count);

    always_ff @(posedge clk) begin
        if (rst) state <= S_HDR0;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_HDR0:  if (hs) next_state = S_HDR1;
            S_HDR1: begin
                if (hs) begin
                    if ({1'b0, hdr_count} > MAX_COUNT) next_state = S_ERROR;
                    else if (hdr_count == 16'd0)       next_state = S_CSUM;
                    else                               next_state = S_DATA;
                end
            end
            S_DATA:  if (hs && last_byte && last_word) next_state = S_CSUM;
            S_CSUM:  if (hs) next_state = (in_data == xsum) ? S_DONE : S_ERROR;
            S_DONE:  if (reload) next_state = S_HDR0;
            S_ERROR: if (reload) next_state = S_HDR0;
            default: next_state = S_HDR0;
        endcase
    end

    // Status outputs are registered from next_state so they change with the state.
    always_comb begin
        in_ready_d = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        cpu_rst_d  = 1'b1;
        case (next_state)
            S_HDR0, S_HDR1, S_DATA, S_CSUM: in_ready_d = 1'b1;
            S_DONE:  begin done_d = 1'b1; cpu_rst_d = 1'b0; end
            S_ERROR: error_d = 1'b1;
            default: in_ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_rst  <= 1'b1;
        end else begin
            in_ready <= in_ready_d;
            done     <= done_d;
            error    <= error_d;
            cpu_rst  <= cpu_rst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_lo     <= 8'd0;
            count        <= 16'd0;
            byte_idx     <= 2'd0;
            xsum         <= 8'd0;
            word_buf     <= 24'd0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 32'd0;
            words_loaded <= 16'd0;
        end else begin
            mem_we <= 1'b0;
            if (state == S_HDR0 && hs) count_lo <= in_data;
            if (state == S_HDR1 && hs) begin
                count        <= hdr_count;
                byte_idx     <= 2'd0;
                xsum         <= 8'd0;
                words_loaded <= 16'd0;
            end
            if (state == S_DATA && hs) begin
                byte_idx <= byte_idx + 2'd1;
                xsum     <= xsum ^ in_data;
                case (byte_idx)
                    2'd0:    word_buf[7:0]   <= in_data;
                    2'd1:    word_buf[15:8]  <= in_data;
                    2'd2:    word_buf[23:16] <= in_data;
                    default: word_buf        <= word_buf;
                endcase
                // The top byte goes straight to the write port, not via word_buf.
                if (last_byte) begin
                    mem_we       <= 1'b1;
                    mem_addr     <= words_loaded[ADDR_W-1:0];
                    mem_wdata    <= {in_data, word_buf};
                    words_loaded <= words_loaded + 16'd1;
                end
            end
            if ((state == S_DONE || state == S_ERROR) && reload) words_loaded <= 16'd0;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: basic load, gapped stream, checksum error,
// oversize/empty headers, mid-load reset and a full-capacity image.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_hs_cyc = 0;

    logic [9:0]  log_addr[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];
    logic [31:0] mem_model[1024];
    logic [7:0]  stim_q[$];

    imem_loader #(.ADDR_W(10), .NUM_WORDS(1024)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .reload(reload), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
        .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
            log_cyc.push_back(cyc);
            mem_model[mem_addr] = mem_wdata;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL handshake_timeout: in_ready=%b required 1 for byte %h", in_ready, b);
        end else begin
            last_hs_cyc = cyc;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input int max_gap);
        foreach (stim_q[i]) send_byte(stim_q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b need 0", in_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b need 0", mem_we); end
        checks++; if (mem_addr !== 10'd0) begin errors++; $display("FAIL rst_mem_addr: got %h need 0", mem_addr); end
        checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL rst_mem_wdata: got %h need 0", mem_wdata); end
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL rst_cpu_rst: got %b need 1", cpu_rst); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL rst_flags: done=%b error=%b need 0 0", done, error); end
        checks++; if (words_loaded !== 16'd0) begin errors++; $display("FAIL rst_words: got %0d need 0", words_loaded); end
        checks++; if (dut.state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d need 0", dut.state); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise: got %b need 1", in_ready); end
    endtask

    task automatic test_basic();
        int hs_a, hs_b, hs_first;
        clear_log();
        stim_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        hs_a = 0; hs_b = 0; hs_first = 0;
        foreach (stim_q[i]) begin
            send_byte(stim_q[i], 0);
            if (i == 0) hs_first = last_hs_cyc;
            if (i == 5) hs_a = last_hs_cyc;
            if (i == 9) hs_b = last_hs_cyc;
        end
        checks++; if (last_hs_cyc - hs_first !== 10) begin errors++; $display("FAIL basic_rate: got %0d cycles need 10", last_hs_cyc - hs_first); end
        checks++; if (log_addr.size() !== 2) begin errors++; $display("FAIL basic_nwrites: got %0d need 2", log_addr.size()); end
        if (log_addr.size() >= 2) begin
            checks++; if (log_addr[0] !== 10'd0 || log_data[0] !== 32'h00000013) begin errors++; $display("FAIL basic_w0: got %h:%h need 0:00000013", log_addr[0], log_data[0]); end
            checks++; if (log_addr[1] !== 10'd1 || log_data[1] !== 32'h00100093) begin errors++; $display("FAIL basic_w1: got %h:%h need 1:00100093", log_addr[1], log_data[1]); end
            checks++; if (log_cyc[0] !== hs_a + 1 || log_cyc[1] !== hs_b + 1) begin errors++; $display("FAIL basic_we_timing: got %0d,%0d need %0d,%0d", log_cyc[0], log_cyc[1], hs_a + 1, hs_b + 1); end
        end
        checks++; if (done !== 1'b1 || cpu_rst !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL basic_done: done=%b cpu_rst=%b error=%b need 1 0 0", done, cpu_rst, error); end
        checks++; if (words_loaded !== 16'd2) begin errors++; $display("FAIL basic_words: got %0d need 2", words_loaded); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready: got %b need 0", in_ready); end
    endtask

    task automatic test_gaps();
        pulse_reload();
        checks++; if (done !== 1'b0 || cpu_rst !== 1'b1 || words_loaded !== 16'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reload_clear: done=%b cpu_rst=%b words=%0d ready=%b need 0 1 0 1", done, cpu_rst, words_loaded, in_ready);
        end
        clear_log();
        stim_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        foreach (stim_q[i]) begin
            send_byte(stim_q[i], int'($urandom_range(0, 5)));
            if (i == 4) pulse_reload();
        end
        checks++; if (log_addr.size() !== 2) begin errors++; $display("FAIL gaps_nwrites: got %0d need 2", log_addr.size()); end
        if (log_addr.size() >= 2) begin
            checks++; if (log_data[0] !== 32'h00000013 || log_data[1] !== 32'h00100093 || log_addr[1] !== 10'd1) begin
                errors++; $display("FAIL gaps_data: got %h,%h@%h need 00000013,00100093@1", log_data[0], log_data[1], log_addr[1]);
            end
        end
        checks++; if (done !== 1'b1 || words_loaded !== 16'd2 || cpu_rst !== 1'b0) begin errors++; $display("FAIL gaps_done: done=%b words=%0d cpu_rst=%b need 1 2 0", done, words_loaded, cpu_rst); end
    endtask

    task automatic test_bad_csum();
        pulse_reload();
        clear_log();
        stim_q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
        send_stream(0);
        checks++; if (log_addr.size() !== 1) begin errors++; $display("FAIL csum_nwrites: got %0d need 1", log_addr.size()); end
        if (log_addr.size() >= 1) begin
            checks++; if (log_addr[0] !== 10'd0 || log_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL csum_w0: got %h:%h need 0:deadbeef", log_addr[0], log_data[0]); end
        end
        checks++; if (error !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL csum_error: error=%b done=%b cpu_rst=%b ready=%b need 1 0 1 0", error, done, cpu_rst, in_ready);
        end
        pulse_reload();
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL csum_reload: error=%b need 0", error); end
        stim_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_stream(0);
        checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL csum_recover: done=%b error=%b need 1 0", done, error); end
    endtask

    task automatic test_oversize_empty();
        pulse_reload();
        clear_log();
        stim_q = '{8'h01, 8'h04};
        send_stream(0);
        checks++; if (error !== 1'b1 || in_ready !== 1'b0 || dut.state !== 3'd5) begin
            errors++; $display("FAIL oversize: error=%b ready=%b state=%0d need 1 0 5", error, in_ready, dut.state);
        end
        repeat (2) @(negedge clk);
        checks++; if (log_addr.size() !== 0) begin errors++; $display("FAIL oversize_nwrites: got %0d need 0", log_addr.size()); end
        pulse_reload();
        stim_q = '{8'h00, 8'h00, 8'h00};
        send_stream(0);
        checks++; if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 16'd0) begin
            errors++; $display("FAIL empty_done: done=%b error=%b words=%0d need 1 0 0", done, error, words_loaded);
        end
        checks++; if (log_addr.size() !== 0) begin errors++; $display("FAIL empty_nwrites: got %0d need 0", log_addr.size()); end
    endtask

    task automatic test_mid_reset();
        pulse_reload();
        clear_log();
        stim_q = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_stream(0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (log_addr.size() !== 1 || log_data[0] !== 32'h44332211) begin errors++; $display("FAIL midrst_partial: n=%0d data=%h need 1 44332211", log_addr.size(), log_data[0]); end
        checks++; if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 10'd0 || mem_wdata !== 32'd0) begin
            errors++; $display("FAIL midrst_port: ready=%b we=%b addr=%h wdata=%h need 0 0 0 0", in_ready, mem_we, mem_addr, mem_wdata);
        end
        checks++; if (cpu_rst !== 1'b1 || done !== 1'b0 || error !== 1'b0 || words_loaded !== 16'd0 || dut.state !== 3'd0) begin
            errors++; $display("FAIL midrst_status: cpu_rst=%b done=%b error=%b words=%0d state=%0d need 1 0 0 0 0", cpu_rst, done, error, words_loaded, dut.state);
        end
        clear_log();
        stim_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_stream(0);
        checks++; if (log_addr.size() !== 2 || log_addr[0] !== 10'd0 || log_data[0] !== 32'h00000013) begin
            errors++; $display("FAIL midrst_reload: n=%0d first=%h:%h need 2 0:00000013", log_addr.size(), log_addr[0], log_data[0]);
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL midrst_done: got %b need 1", done); end
    endtask

    task automatic test_full();
        logic [31:0] w;
        logic [7:0]  cs;
        int          bad;
        pulse_reload();
        clear_log();
        cs = 8'd0;
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        for (int i = 0; i < 1024; i++) begin
            w = 32'h0100_0000 + 32'(i);
            for (int b = 0; b < 4; b++) begin
                cs = cs ^ w[b*8 +: 8];
                send_byte(w[b*8 +: 8], 0);
            end
        end
        send_byte(cs, 0);
        checks++; if (log_addr.size() !== 1024) begin errors++; $display("FAIL full_nwrites: got %0d need 1024", log_addr.size()); end
        if (log_addr.size() == 1024) begin
            bad = 0;
            for (int i = 0; i < 1024; i++) if (log_addr[i] !== 10'(i)) bad++;
            checks++; if (bad !== 0) begin errors++; $display("FAIL full_addr_seq: %0d out-of-order addresses need 0", bad); end
            checks++; if (log_addr[1023] !== 10'd1023 || log_data[1023] !== 32'h010003FF) begin
                errors++; $display("FAIL full_last: got %h:%h need 3ff:010003ff", log_addr[1023], log_data[1023]);
            end
        end
        checks++; if (mem_model[0] !== 32'h01000000) begin errors++; $display("FAIL full_first: got %h need 01000000", mem_model[0]); end
        checks++; if (words_loaded !== 16'd1024 || done !== 1'b1 || cpu_rst !== 1'b0) begin
            errors++; $display("FAIL full_done: words=%0d done=%b cpu_rst=%b need 1024 1 0", words_loaded, done, cpu_rst);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_bad_csum();
        test_oversize_empty();
        test_mid_reset();
        do_reset();
        test_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
